pipelined_csel_adder: RTL and testbench
=======================================

PIPELINED_CSEL_ADDER -- requirements
Module: pipelined_csel_adder

Interface
REQ-001 Parameter WIDTH, default 16, operand/result width in bits; SHALL be a multiple of STAGES, minimum 2.
REQ-002 Parameter STAGES, default 4, number of pipeline stages (1..WIDTH); chunk width CW = WIDTH/STAGES.
REQ-003 clk  in  1  single clock; all state SHALL update on its rising edge.
REQ-004 rst_n  in  1  synchronous, active-high reset (asserted = 1, sampled on clk).
REQ-005 in_valid  in  1  operand beat valid.
REQ-006 in_ready  out  1  block accepts a beat this cycle.
REQ-007 a  in  WIDTH  operand A.
REQ-008 b  in  WIDTH  operand B.
REQ-009 cin  in  1  carry-in (add) / borrow-in (sub).
REQ-010 sub  in  1  0 = a+b+cin; 1 = a-b-cin.
REQ-011 out_ready  in  1  consumer accepts result.
REQ-012 guard  out  1  result valid.
REQ-013 value  out  WIDTH  result, modulo 2^WIDTH.
REQ-014 cout  out  1  carry-out (add); NOT borrow (sub: 1 = no borrow).
REQ-015 ovf  out  1  two's-complement signed overflow of the operation.

Function
REQ-016 Beat accepted iff in_valid && in_ready at a rising edge; result transferred iff guard && out_ready.
REQ-017 sub=1 SHALL be computed as a + ~b + !cin; cout is the raw carry of that sum.
REQ-018 Stage k (0..STAGES-1) SHALL add chunk k of the operands using carry-select: both chunk sums (carry 0 and 1) computed, selected by the registered carry from stage k-1 (stage 0 uses the effective carry-in).
REQ-019 Lower chunks already summed and upper operand chunks not yet summed SHALL travel with the beat unchanged; sub SHALL be applied (b inverted) before stage 0 registers.
REQ-020 Each stage holds one valid bit; stage k advances when valid[k+1]=0 or stage k+1 advances; last stage advances when out_ready=1.
REQ-021 in_ready = !valid[0] || stage 0 advances (combinational, bubble-collapsing, no dead cycle under full throughput).
REQ-022 Latency: a beat accepted at edge n SHALL present guard=1 after edge n+STAGES-1 when no stall occurs (STAGES=1: visible after the accepting edge).
REQ-023 Throughput: one result per cycle while in_valid=1 and out_ready=1.
REQ-024 guard, value, cout, ovf SHALL be driven from the last stage registers and held stable while guard=1 and out_ready=0.
REQ-025 ovf = (sign(a) == sign(b')) && (sign(value) != sign(a)), where b' is b (add) or ~b (sub).
REQ-026 Order SHALL be preserved; no beat dropped or duplicated under any out_ready pattern.
REQ-027 Full pipe (all STAGES valid) with out_ready=0: in_ready=0; simultaneous accept and drain in the same cycle SHALL both occur.
REQ-028 guard=1 with out_ready=0 SHALL never change value.

Reset
REQ-029 While rst_n=1: all valid bits 0, guard=0, value=0, cout=0, ovf=0; in-flight beats discarded.
REQ-030 First cycle after rst_n deasserts: in_ready=1; no result presented until a new beat completes.
REQ-031 Reset asserted mid-stream SHALL clear guard on the next edge; no stale result SHALL reappear.

Structure
REQ-032 Package adder_pkg SHALL hold default WIDTH/STAGES, the sub-mode encoding, and the stage-payload record layout (valid, partial sum, carry, remaining operands, sign bits).
REQ-033 One sub-module csel_slice (parameter CW): combinational chunk adder producing sum0/carry0 and sum1/carry1; instantiated once per stage.

Verification (WIDTH=16, STAGES=4)
REQ-034 a=0xFFFF, b=0x0001, cin=0, sub=0, out_ready=1 -> value=0x0000, cout=1, ovf=0, guard exactly 3 cycles after accept edge.
REQ-035 a=0x7FFF, b=0x0001, cin=0, sub=0 -> value=0x8000, cout=0, ovf=1.
REQ-036 a=0x0005, b=0x0007, cin=0, sub=1 -> value=0xFFFE, cout=0, ovf=0; a=0x8000, b=0x0001, sub=1 -> 0x7FFF, ovf=1.
REQ-037 16 back-to-back random beats, out_ready=1 -> 16 results on consecutive cycles, in order, matching a reference model.
REQ-038 Stream with out_ready=0 for 10 cycles -> exactly 4 beats accepted, in_ready=0 thereafter, value stable; release -> all 4 drain in order, none lost.
REQ-039 rst_n=1 for one cycle with 3 beats in flight -> guard=0 next cycle, no pre-reset result ever appears, in_ready=1 after release.

Source files
------------

// File: rtl/adder_pkg.sv
// adder_pkg: shared defaults, mode encoding and stage payload layout for pipelined_csel_adder
package adder_pkg;
  localparam int DEF_WIDTH = 16;
  localparam int DEF_STAGES = 4;
  localparam int MAX_WIDTH = 64;
  typedef enum logic {MODE_ADD = 1'b0, MODE_SUB = 1'b1} mode_e;
  // Fields are sized for MAX_WIDTH; the top uses only the low WIDTH bits.
  typedef struct packed {
    logic                 valid;
    logic [MAX_WIDTH-1:0] sum;
    logic                 carry;
    logic [MAX_WIDTH-1:0] a;
    logic [MAX_WIDTH-1:0] b;
    logic                 sign_a;
    logic                 sign_b;
  } stage_t;
endpackage

// File: rtl/csel_slice.sv
// csel_slice: carry-select chunk adder, both carry-in outcomes computed in parallel
module csel_slice #(
  parameter int CW = 4
) (
  input  logic [CW-1:0] i_a,
  input  logic [CW-1:0] i_b,
  output logic [CW-1:0] o_sum0,
  output logic [CW-1:0] o_sum1,
  output logic          o_carry0,
  output logic          o_carry1
);
  assign {o_carry0, o_sum0} = {1'b0, i_a} + {1'b0, i_b};
  assign {o_carry1, o_sum1} = {1'b0, i_a} + {1'b0, i_b} + (CW+1)'(1);
endmodule

// File: rtl/pipelined_csel_adder.sv
// pipelined_csel_adder: add/sub pipelined one chunk per stage with carry-select and valid/ready flow control
module pipelined_csel_adder
  import adder_pkg::*;
#(
  parameter int WIDTH  = DEF_WIDTH,
  parameter int STAGES = DEF_STAGES
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             in_valid,
  output logic             in_ready,
  input  logic [WIDTH-1:0] a,
  input  logic [WIDTH-1:0] b,
  input  logic             cin,
  input  logic             sub,
  input  logic             out_ready,
  output logic             guard,
  output logic [WIDTH-1:0] value,
  output logic             cout,
  output logic             ovf
);
  localparam int CW = WIDTH / STAGES;
  mode_e             w_mode;
  logic [WIDTH-1:0]  w_b;
  stage_t            w_src;
  stage_t            w_nxt [STAGES];
  stage_t            r_st  [STAGES];
  logic [STAGES:0]   w_rdy;
  assign w_mode = mode_e'(sub);
  assign w_b    = (w_mode == MODE_SUB) ? ~b : b;
  // Subtraction becomes a + ~b + !cin, so the effective carry-in is cin flipped.
  always_comb begin
    w_src                = '0;
    w_src.valid          = in_valid;
    w_src.carry          = cin ^ (w_mode == MODE_SUB);
    w_src.a[WIDTH-1:0]   = a;
    w_src.b[WIDTH-1:0]   = w_b;
    w_src.sign_a         = a[WIDTH-1];
    w_src.sign_b         = w_b[WIDTH-1];
  end
  // A stage may load when empty or when the stage after it is loading too.
  always_comb begin
    w_rdy         = '0;
    w_rdy[STAGES] = out_ready;
    for (int i = STAGES - 1; i >= 0; i--)
      w_rdy[i] = !r_st[i].valid || w_rdy[i+1];
  end
  assign in_ready = w_rdy[0];
  for (genvar k = 0; k < STAGES; k++) begin : g_st
    stage_t          w_in;
    stage_t          w_out;
    logic [CW-1:0]   w_s0;
    logic [CW-1:0]   w_s1;
    logic            w_c0;
    logic            w_c1;
    if (k == 0) begin : g_first
      assign w_in = w_src;
    end else begin : g_next
      assign w_in = r_st[k-1];
    end
    csel_slice #(.CW(CW)) u_slice (
      .i_a      (w_in.a[k*CW +: CW]),
      .i_b      (w_in.b[k*CW +: CW]),
      .o_sum0   (w_s0),
      .o_sum1   (w_s1),
      .o_carry0 (w_c0),
      .o_carry1 (w_c1)
    );
    always_comb begin
      w_out                   = w_in;
      w_out.sum[k*CW +: CW]   = w_in.carry ? w_s1 : w_s0;
      w_out.carry             = w_in.carry ? w_c1 : w_c0;
    end
    assign w_nxt[k] = w_out;
  end
  always_ff @(posedge clk)
    for (int i = 0; i < STAGES; i++)
      if (rst_n) r_st[i] <= '0;
      else if (w_rdy[i]) r_st[i] <= w_nxt[i].valid ? w_nxt[i] : '0;
  assign guard = r_st[STAGES-1].valid;
  assign value = r_st[STAGES-1].sum[WIDTH-1:0];
  assign cout  = r_st[STAGES-1].carry;
  assign ovf   = (r_st[STAGES-1].sign_a == r_st[STAGES-1].sign_b) &&
                 (value[WIDTH-1] != r_st[STAGES-1].sign_a);
endmodule

// File: tb/tb_pipelined_csel_adder.sv
// tb_pipelined_csel_adder: directed and random checks of the pipelined adder against an arithmetic reference
module tb_pipelined_csel_adder;
  logic        clk = 1'b0;
  logic        rst_n = 1'b1;
  logic        in_valid = 1'b0;
  logic        cin = 1'b0;
  logic        sub = 1'b0;
  logic        out_ready = 1'b0;
  logic [15:0] a = 16'h0;
  logic [15:0] b = 16'h0;
  logic        in_ready, guard, cout, ovf;
  logic [15:0] value;
  int          n_chk = 0;
  int          n_fail = 0;
  logic [17:0] q[$];
  always #5 clk = ~clk;
  pipelined_csel_adder #(.WIDTH(16), .STAGES(4)) dut (
    .clk(clk), .rst_n(rst_n), .in_valid(in_valid), .in_ready(in_ready),
    .a(a), .b(b), .cin(cin), .sub(sub), .out_ready(out_ready),
    .guard(guard), .value(value), .cout(cout), .ovf(ovf)
  );
  // Reference: {value, cout, ovf} from integer arithmetic on the operands.
  function automatic logic [17:0] model(logic [15:0] x, logic [15:0] y, logic c, logic s);
    int u, v;
    u = s ? int'(x) - int'(y) - int'(c) : int'(x) + int'(y) + int'(c);
    v = s ? int'($signed(x)) - int'($signed(y)) - int'(c)
          : int'($signed(x)) + int'($signed(y)) + int'(c);
    return {u[15:0], s ? (u >= 0) : (u > 65535), (v > 32767) || (v < -32768)};
  endfunction
  task automatic chk(string tag, logic [31:0] obs, logic [31:0] exp);
    n_chk++;
    assert (obs === exp) else begin
      n_fail++;
      $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    end
  endtask
  task automatic step(logic iv, logic [15:0] ia, logic [15:0] ib, logic ic, logic is, logic ordy);
    logic [17:0] e;
    in_valid = iv; a = ia; b = ib; cin = ic; sub = is; out_ready = ordy;
    #1;
    if (guard && out_ready && !rst_n) begin
      chk("extra_result", 32'(q.size() != 0), 1);
      if (q.size() != 0) begin
        e = q.pop_front();
        chk("result", 32'({value, cout, ovf}), 32'(e));
      end
    end
    if (in_valid && in_ready && !rst_n) q.push_back(model(ia, ib, ic, is));
    @(posedge clk);
    #1;
  endtask
  task automatic idle(logic ordy);
    step(1'b0, 16'h0, 16'h0, 1'b0, 1'b0, ordy);
  endtask
  task automatic rnd(logic iv, logic ordy);
    step(iv, 16'($urandom), 16'($urandom), 1'($urandom), 1'($urandom), ordy);
  endtask
  task automatic directed(string tag, logic [15:0] x, logic [15:0] y, logic c, logic s, logic [17:0] exp);
    step(1'b1, x, y, c, s, 1'b1);
    for (int i = 0; i < 3; i++) begin
      chk({tag, "_early_guard"}, 32'(guard), 0);
      idle(1'b1);
    end
    chk({tag, "_guard"}, 32'(guard), 1);
    chk({tag, "_res"}, 32'({value, cout, ovf}), 32'(exp));
    idle(1'b1);
  endtask
  initial begin
    logic        held;
    logic        ordy;
    logic [17:0] hv;
    idle(1'b0);
    idle(1'b0);
    chk("rst_guard", 32'(guard), 0);
    chk("rst_value", 32'(value), 0);
    chk("rst_cout", 32'(cout), 0);
    chk("rst_ovf", 32'(ovf), 0);
    rst_n = 1'b0;
    #1;
    chk("rst_release_in_ready", 32'(in_ready), 1);
    directed("wrap", 16'hFFFF, 16'h0001, 1'b0, 1'b0, {16'h0000, 1'b1, 1'b0});
    directed("pos_ovf", 16'h7FFF, 16'h0001, 1'b0, 1'b0, {16'h8000, 1'b0, 1'b1});
    directed("sub_neg", 16'h0005, 16'h0007, 1'b0, 1'b1, {16'hFFFE, 1'b0, 1'b0});
    directed("sub_ovf", 16'h8000, 16'h0001, 1'b0, 1'b1, {16'h7FFF, 1'b1, 1'b1});
    for (int i = 0; i < 19; i++) begin
      if (i < 16) begin
        chk("burst_in_ready", 32'(in_ready), 1);
        rnd(1'b1, 1'b1);
      end else idle(1'b1);
      chk("burst_guard", 32'(guard), (i >= 3) ? 1 : 0);
    end
    idle(1'b1);
    chk("burst_after_guard", 32'(guard), 0);
    chk("burst_drained", q.size(), 0);
    for (int i = 0; i < 10; i++) begin
      chk("stall_in_ready", 32'(in_ready), (i < 4) ? 1 : 0);
      rnd(1'b1, 1'b0);
      if (i >= 3) begin
        chk("stall_guard", 32'(guard), 1);
        chk("stall_hold", 32'({value, cout, ovf}), 32'(q[0]));
      end
    end
    chk("stall_accepted", q.size(), 4);
    in_valid = 1'b1;
    out_ready = 1'b1;
    #1;
    chk("full_accept_drain", 32'(in_ready), 1);
    rnd(1'b1, 1'b1);
    for (int i = 0; i < 5; i++) idle(1'b1);
    chk("stall_drained", q.size(), 0);
    for (int i = 0; i < 200; i++) begin
      ordy = 1'($urandom_range(0, 2) != 0);
      held = guard && !ordy;
      hv = {value, cout, ovf};
      rnd(1'($urandom), ordy);
      if (held) begin
        chk("hold_guard", 32'(guard), 1);
        chk("hold_value", 32'({value, cout, ovf}), 32'(hv));
      end
    end
    for (int i = 0; i < 6; i++) idle(1'b1);
    chk("random_drained", q.size(), 0);
    for (int i = 0; i < 3; i++) rnd(1'b1, 1'b1);
    rst_n = 1'b1;
    idle(1'b0);
    chk("midrst_guard", 32'(guard), 0);
    chk("midrst_value", 32'(value), 0);
    q.delete();
    rst_n = 1'b0;
    #1;
    chk("midrst_in_ready", 32'(in_ready), 1);
    for (int i = 0; i < 6; i++) begin
      idle(1'b1);
      chk("no_stale", 32'(guard), 0);
    end
    directed("post_rst", 16'h1234, 16'h1111, 1'b1, 1'b0, {16'h2346, 1'b0, 1'b0});
    chk("final_empty", q.size(), 0);
    $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
    $finish;
  end
endmodule
